// File: rtl/ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb_apb_bridge
// Brief    : AHB-Lite slave converting single 32-bit transfers into APB3
//            SETUP/ACCESS sequences for one peripheral, with pready timeout.
// Revision : 1.0
// ============================================================================
module ahb_apb_bridge #(
  parameter int PADDR_WIDTH = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   hsel,
  input  logic [31:0]            haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic                   hready,
  input  logic [31:0]            hwdata,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic [31:0]            hrdata,
  output logic [PADDR_WIDTH-1:0] paddr,
  output logic                   pwrite,
  output logic                   psel,
  output logic                   penable,
  output logic [31:0]            pwdata,
  input  logic [31:0]            prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int              CNT_W   = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit              TMO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W:0]  TMO_LIM = TIMEOUT[CNT_W:0];
  localparam logic [CNT_W:0]  CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic [31:0]            hrdata_q, hrdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         cnt_inc;
  logic                   accept;

  assign accept  = hsel & hready & htrans[1];
  // One extra bit so the increment can be tested for saturation.
  assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

  generate
    if (PADDR_WIDTH < 32) begin : g_unused_addr
      logic unused_haddr_hi;
      assign unused_haddr_hi = ^haddr[31:PADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          paddr_d  = haddr[PADDR_WIDTH-1:0];
          pwrite_d = hwrite;
          state_d  = (hsize == 3'b010) ? S_WAIT : S_ERR1;
        end
      end
      S_WAIT: begin
        pwdata_d = hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_IDLE;
            if (!pwrite_q) hrdata_d = prdata;
          end
        end else begin
          cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
          if (TMO_EN && (cnt_inc >= TMO_LIM)) state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    hreadyout = 1'b0;
    hresp     = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      S_IDLE:   hreadyout = 1'b1;
      S_SETUP:  psel = 1'b1;
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      S_ERR1:   hresp = 1'b1;
      S_ERR2: begin
        hreadyout = 1'b1;
        hresp     = 1'b1;
      end
      default: ;
    endcase
  end

  assign paddr  = paddr_q;
  assign pwrite = pwrite_q;
  assign pwdata = pwdata_q;
  assign hrdata = hrdata_q;

endmodule
`default_nettype wire

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-Lite slave that converts single 32-bit AHB transfers into APB3 transfers for one downstream peripheral. Occupies one slave slot behind the address decoder and response multiplexor: takes hsel from the decoder, and returns hreadyout/hresp/hrdata to the multiplexor. Adds address-phase capture, write-data registering, APB SETUP/ACCESS sequencing, wait-state propagation, a pready timeout, and the two-cycle AHB ERROR response.

## Interface
- PADDR_WIDTH, 16: APB address width; paddr = captured haddr[PADDR_WIDTH-1:0].
- TIMEOUT, 255: max ACCESS cycles waiting for pready before forced error; 0 disables timeout.
- hclk  in  1  clock, all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select from decoder.
- haddr  in  32  AHB address.
- htrans  in  2  transfer type; only NONSEQ/SEQ (htrans[1]=1) start transfers.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size; only 3'b010 legal.
- hready  in  1  bus-wide ready (multiplexor output).
- hwdata  in  32  write data, valid in data phase.
- hreadyout  out  1  slave ready to multiplexor.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data, registered.
- paddr  out  PADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  32  APB write data, registered.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

## Operation
- Accept = hsel & hready & htrans[1], sampled only in IDLE or ERR2; otherwise ignored.
- On accept: register haddr, hwrite, hsize. hsize != 3'b010 -> ERR1 (no APB access); else -> WAIT.
- States and outputs (hreadyout/hresp/psel/penable): IDLE 1/0/0/0; WAIT 0/0/0/0; SETUP 0/0/1/0; ACCESS 0/0/1/1; ERR1 0/1/0/0; ERR2 1/1/0/0.
- WAIT: pwdata <= hwdata (data phase); -> SETUP unconditionally (read and write).
- SETUP -> ACCESS unconditionally; timeout counter cleared.
- ACCESS: pready=1 & pslverr=0 -> IDLE, hrdata <= prdata on reads (hrdata unchanged on writes). pready=1 & pslverr=1 -> ERR1. pready=0 -> stay, counter +1; counter reaching TIMEOUT (TIMEOUT!=0) -> ERR1, psel/penable drop.
- ERR1 -> ERR2 -> IDLE (ERR2 may accept a new transfer, which overrides -> WAIT/ERR1).
- paddr, pwrite, pwdata hold stable from SETUP through end of ACCESS.
- Counter 8+ bits wide enough for TIMEOUT, saturating, never wraps.

## Timing
- Reset (hreset=1 at edge): state IDLE, hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, counter=0. Reset mid-transfer aborts: next cycle psel=penable=0, hreadyout=1, no error reported.
- Zero-wait APB: address phase cycle T; WAIT T+1, SETUP T+2, ACCESS T+3 (pready=1), IDLE T+4 with hreadyout=1 and hrdata valid -> 3 AHB wait states.
- Each APB cycle with pready=0 adds one AHB wait state.
- Back-to-back: address phase presented in the completing IDLE cycle (T+4) is accepted; its SETUP at T+6.
- Error: ERROR visible two cycles (hreadyout 0 then 1, hresp=1 both).
- Timeout: with pready stuck 0, ERR1 entered TIMEOUT ACCESS cycles after first ACCESS cycle.
- htrans IDLE/BUSY or hsel=0 in IDLE: hreadyout stays 1, hresp 0, no APB activity.

## Test plan
- Write 0xDEADBEEF to haddr 0x0000_0010, pready=1 -> psel at T+2, penable at T+3, paddr=0x0010, pwrite=1, pwdata=0xDEADBEEF; hreadyout=1, hresp=0 at T+4.
- Read haddr 0x0004, pready low 2 ACCESS cycles then 1 with prdata=0x1234_5678 -> hreadyout low T+1..T+5, hrdata=0x1234_5678 at T+6.
- Read with pslverr=1 at pready -> hreadyout 0/hresp 1, then hreadyout 1/hresp 1, then IDLE OKAY; hrdata unchanged.
- hsize=3'b000 write -> no psel pulse, two-cycle ERROR response.
- TIMEOUT=4, pready held 0 -> penable high exactly 4 cycles, then ERROR sequence; back-to-back write accepted during ERR2 completes OKAY.
- hreset pulsed during ACCESS -> next cycle psel=penable=0, hreadyout=1, hresp=0; subsequent read works normally.
